bus_mem_slave: RTL and testbench
================================

BUS_MEM_SLAVE -- requirements
Module: bus_mem_slave

Interface
REQ-001 SHALL take parameter BASE_ADDR, default 32'h0000_0000, byte base address of the decoded window.
REQ-002 SHALL take parameter ADDR_BITS, default 8, log2 of the word depth (window = 4*2^ADDR_BITS bytes).
REQ-003 SHALL take parameter WAIT_CYCLES, default 2, wait states inserted before the response (0..15).
REQ-004 SHALL have port clk  input  1  single system clock, rising-edge.
REQ-005 SHALL have port clr  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port BUS_addr  input  32  byte address from the granted master.
REQ-007 SHALL have port BUS_data  inout  32  shared data bus; driven by this block only during its read response.
REQ-008 SHALL have port BUS_req  input  1  level request from the granted master.
REQ-009 SHALL have port BUS_RW  input  1  1 = write, 0 = read.
REQ-010 SHALL have port BUS_ready  output  1  one-cycle completion strobe; the top level ORs all slave strobes.

Function
REQ-011 SHALL select only when BUS_addr is in [BASE_ADDR, BASE_ADDR + 4*2^ADDR_BITS); otherwise ignore the request entirely.
REQ-012 SHALL word-index with BUS_addr[ADDR_BITS+1:2] and ignore BUS_addr[1:0].
REQ-013 SHALL implement FSM IDLE, WAIT, RESP, RELEASE.
REQ-014 IDLE: on a clock edge with BUS_req=1 and the address selected, SHALL latch address, RW, and write data (BUS_data); go to WAIT with count=WAIT_CYCLES, or to RESP directly if WAIT_CYCLES=0.
REQ-015 WAIT: SHALL decrement count each edge and go to RESP on the edge where count is 1.
REQ-016 WAIT: if BUS_req=0 at an edge, SHALL abort to IDLE, with no write commit and no BUS_ready.
REQ-017 RESP: BUS_ready=1 for exactly this one cycle; the next edge SHALL go to RELEASE.
REQ-018 Latency: BUS_ready SHALL go high WAIT_CYCLES+1 cycles after the accepting edge (1 cycle when WAIT_CYCLES=0).
REQ-019 Write: SHALL commit the latched data to the latched word on the edge entering RESP.
REQ-020 Read: SHALL capture the addressed word in a data register on the edge entering RESP, and drive BUS_data from that register only while in RESP; at all other times BUS_data is 'z'.
REQ-021 RELEASE: SHALL remain until BUS_req=0 at an edge, then go to IDLE; no back-to-back accept without an intervening req-low edge.
REQ-022 A read following a write to the same word SHALL return the written data.
REQ-023 BUS_RW and BUS_addr changes after acceptance SHALL have no effect on the transaction in flight.

Reset
REQ-024 clr=1 SHALL immediately force state=IDLE, count=0, BUS_ready=0, and BUS_data='z', regardless of the clock.
REQ-025 Reset mid-WAIT SHALL drop the transaction without a write commit.
REQ-026 Memory array contents SHALL NOT be cleared by reset and SHALL be undefined at power-up, unless preloaded by the bench.

Structure
REQ-027 State encodings and the default parameter values SHALL live in the shared bus include/package used by bus_control and the cache.
REQ-028 The storage SHALL be one sub-module, bus_sram_array: synchronous write, registered read, 32-bit words, depth 2^ADDR_BITS.
REQ-029 The FSM, decode, wait counter, and tri-state driver SHALL live in bus_mem_slave.

Verification
REQ-030 Reset, then read addr 0 with WAIT_CYCLES=2 and word0 preloaded 32'h0ab2112a -> BUS_ready high exactly 3 cycles after the accept edge; BUS_data=32'h0ab2112a in that cycle only, 'z' before and after.
REQ-031 Write addr 16 data 32'h0ab21123, then read addr 16 -> read returns 32'h0ab21123; addr 16 and addr 19 alias the same word.
REQ-032 Request to addr BASE_ADDR+4*2^ADDR_BITS -> no BUS_ready and BUS_data stays 'z' for 20 cycles.
REQ-033 Write addr 8 with BUS_req dropped after 1 WAIT cycle, then read addr 8 -> old value returned; no BUS_ready during the aborted access.
REQ-034 Hold BUS_req high for 5 cycles after BUS_ready -> exactly one BUS_ready pulse; the next request is accepted only after a req-low edge.
REQ-035 Assert clr asynchronously mid-RESP of a read -> BUS_ready and BUS_data release within the same cycle; state=IDLE; with WAIT_CYCLES=0, BUS_ready follows the accept edge by 1 cycle.

Source files
------------

// File: rtl/bus_mem_slave_pkg.sv
// Shared bus definitions: slave FSM state encoding and the default
// parameter values used by the memory slave, bus_control and the cache.
// No ports (package).
package bus_mem_slave_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RESP    = 2'd2,
    ST_RELEASE = 2'd3
  } bus_state_e;

  localparam logic [31:0] BUS_BASE_ADDR_DEF   = 32'h0000_0000;
  localparam int          BUS_ADDR_BITS_DEF   = 8;
  localparam int          BUS_WAIT_CYCLES_DEF = 2;
  localparam int          BUS_CNT_W           = 4;   // holds 0..15 wait states

endpackage

// File: rtl/bus_mem_slave_sram_array.sv
// Single-port word SRAM: synchronous write, registered read, no reset on
// the storage or the read register.
// Ports:
//   clk      system clock, rising edge
//   we_i     write enable
//   re_i     read enable, loads rdata_o on the edge
//   addr_i   word index
//   wdata_i  write data
//   rdata_o  registered read data
module bus_sram_array #(
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic                 re_i,
  input  logic [ADDR_BITS-1:0] addr_i,
  input  logic [31:0]          wdata_i,
  output logic [31:0]          rdata_o
);

  logic [31:0] mem_q [2**ADDR_BITS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bus_mem_slave.sv
// Memory slave on the shared tri-state bus: window decode, request FSM with
// programmable wait states, and the read-data bus driver.
// Ports:
//   clk        system clock, rising edge
//   clr        asynchronous active-high reset
//   BUS_addr   byte address from the granted master
//   BUS_data   shared data bus, driven here only during a read response
//   BUS_req    level request from the granted master
//   BUS_RW     1 = write, 0 = read
//   BUS_ready  one-cycle completion strobe
module bus_mem_slave
  import bus_mem_slave_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = BUS_BASE_ADDR_DEF,
  parameter int          ADDR_BITS   = BUS_ADDR_BITS_DEF,
  parameter int          WAIT_CYCLES = BUS_WAIT_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] BUS_addr,
  inout  wire  [31:0] BUS_data,
  input  logic        BUS_req,
  input  logic        BUS_RW,
  output logic        BUS_ready
);

  // 33-bit bounds so a window ending at the top of the address map does
  // not wrap to zero.
  localparam logic [32:0] WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [32:0] WIN_HI = WIN_LO + (33'd4 << ADDR_BITS);
  localparam logic [BUS_CNT_W-1:0] WAIT_INIT = BUS_CNT_W'(WAIT_CYCLES);

  bus_state_e             state_q, state_d;
  logic [BUS_CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_BITS-1:0]   addr_q;
  logic                   rw_q;
  logic [31:0]            wdata_q;

  logic                   sel;
  logic                   accept;
  logic                   mem_we, mem_re;
  logic [ADDR_BITS-1:0]   live_idx, mem_addr;
  logic [31:0]            mem_wdata, mem_rdata;

  assign sel      = ({1'b0, BUS_addr} >= WIN_LO) && ({1'b0, BUS_addr} < WIN_HI);
  assign live_idx = BUS_addr[ADDR_BITS+1:2];

  // With zero wait states RESP is entered on the accepting edge itself, so
  // the array must see the live bus values; otherwise the latched copies.
  assign mem_addr  = (state_q == ST_IDLE) ? live_idx : addr_q;
  assign mem_wdata = (state_q == ST_IDLE) ? BUS_data : wdata_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    mem_we  = 1'b0;
    mem_re  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (BUS_req && sel) begin
          accept = 1'b1;
          if (WAIT_INIT == '0) begin
            state_d = ST_RESP;
            mem_we  = BUS_RW;
            mem_re  = !BUS_RW;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (!BUS_req) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == BUS_CNT_W'(1)) begin
          state_d = ST_RESP;
          cnt_d   = '0;
          mem_we  = rw_q;
          mem_re  = !rw_q;
        end else begin
          cnt_d = cnt_q - BUS_CNT_W'(1);
        end
      end
      ST_RESP: state_d = ST_RELEASE;
      ST_RELEASE: begin
        if (!BUS_req) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= live_idx;
        rw_q    <= BUS_RW;
        wdata_q <= BUS_data;
      end
    end
  end

  bus_sram_array #(.ADDR_BITS(ADDR_BITS)) u_sram (
    .clk     (clk),
    .we_i    (mem_we),
    .re_i    (mem_re),
    .addr_i  (mem_addr),
    .wdata_i (mem_wdata),
    .rdata_o (mem_rdata)
  );

  assign BUS_ready = (state_q == ST_RESP);
  assign BUS_data  = (state_q == ST_RESP && !rw_q) ? mem_rdata : 32'hzzzz_zzzz;

endmodule

// File: tb/tb_bus_mem_slave.sv
module tb_bus_mem_slave;

  localparam int          W1   = 2;
  localparam int          W0   = 0;
  localparam logic [31:0] ALL1 = 32'hffff_ffff;   // pulled-up idle bus

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        req0 = 0, rw0 = 0, den0 = 0, req1 = 0, rw1 = 0, den1 = 0;
  logic [31:0] addr0 = 0, dv0 = 0, addr1 = 0, dv1 = 0;
  wire  [31:0] bus0, bus1;
  wire         rdy0, rdy1;

  assign bus0 = den0 ? dv0 : 32'hzzzz_zzzz;
  assign bus1 = den1 ? dv1 : 32'hzzzz_zzzz;

  for (genvar g = 0; g < 32; g++) begin : g_pu
    pullup pu0 (bus0[g]);
    pullup pu1 (bus1[g]);
  end

  bus_mem_slave #(.BASE_ADDR(32'h0), .ADDR_BITS(8), .WAIT_CYCLES(W1)) dut1 (
    .clk(clk), .clr(clr), .BUS_addr(addr1), .BUS_data(bus1),
    .BUS_req(req1), .BUS_RW(rw1), .BUS_ready(rdy1));

  bus_mem_slave #(.BASE_ADDR(32'h0), .ADDR_BITS(8), .WAIT_CYCLES(W0)) dut0 (
    .clk(clk), .clr(clr), .BUS_addr(addr0), .BUS_data(bus0),
    .BUS_req(req0), .BUS_RW(rw0), .BUS_ready(rdy0));

  typedef struct {
    logic        rd;
    logic [31:0] data;
    int          cyc;
    string       nm;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Monitors: pop the expected response whenever a DUT strobes ready.
  always @(negedge clk) begin
    exp_t e;
    if (!clr) begin
      if (rdy1) begin
        if (q1.size() == 0) chk("dut1_unexpected_ready", {31'b0, rdy1}, 32'd0);
        else begin
          e = q1.pop_front();
          chk({e.nm, "_latency"}, cyc, e.cyc);
          if (e.rd) chk({e.nm, "_data"}, bus1, e.data);
          else if (!den1) chk({e.nm, "_wr_bus_z"}, bus1, ALL1);
        end
      end else if (!den1) chk("dut1_bus_released", bus1, ALL1);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!clr) begin
      if (rdy0) begin
        if (q0.size() == 0) chk("dut0_unexpected_ready", {31'b0, rdy0}, 32'd0);
        else begin
          e = q0.pop_front();
          chk({e.nm, "_latency"}, cyc, e.cyc);
          if (e.rd) chk({e.nm, "_data"}, bus0, e.data);
          else if (!den0) chk({e.nm, "_wr_bus_z"}, bus0, ALL1);
        end
      end else if (!den0) chk("dut0_bus_released", bus0, ALL1);
    end
  end

  task automatic drive(input int k, input logic req, input logic rw,
                       input logic [31:0] addr, input logic [31:0] wd, input logic den);
    if (k == 0) begin req0 = req; rw0 = rw; addr0 = addr; dv0 = wd; den0 = den; end
    else        begin req1 = req; rw1 = rw; addr1 = addr; dv1 = wd; den1 = den; end
  endtask

  // Called just after a rising edge. After the accept edge the address and
  // direction are perturbed to show they no longer matter.
  task automatic issue(input int k, input logic rw, input logic [31:0] addr,
                       input logic [31:0] wd, input int n_hi,
                       input logic [31:0] exp_rd, input string nm);
    exp_t e;
    int   w;
    w      = (k == 0) ? W0 : W1;
    e.rd   = !rw;
    e.data = exp_rd;
    e.cyc  = cyc + 1 + w;
    e.nm   = nm;
    if (k == 0) q0.push_back(e); else q1.push_back(e);
    drive(k, 1'b1, rw, addr, wd, rw);
    for (int i = 0; i < n_hi; i++) begin
      @(posedge clk); #2;
      if (i == 0) drive(k, 1'b1, !rw, addr ^ 32'h4, wd, 1'b0);
    end
    drive(k, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(posedge clk); #2;
  endtask

  initial begin
    #3;
    chk("rst_ready1", {31'b0, rdy1}, 32'd0);
    chk("rst_bus1_z", bus1, ALL1);
    chk("rst_ready0", {31'b0, rdy0}, 32'd0);
    chk("rst_bus0_z", bus0, ALL1);
    @(posedge clk); #2; clr = 1'b0;
    @(posedge clk); #2;

    issue(1, 1'b1, 32'd0,  32'h0ab2112a, W1+3, 32'h0, "wr_w0");
    issue(1, 1'b1, 32'd8,  32'h11112222, W1+3, 32'h0, "wr_a8");
    issue(1, 1'b1, 32'd24, 32'h24242424, W1+3, 32'h0, "wr_a24");

    // reset between edges must not touch memory contents
    #1; clr = 1'b1; #3; clr = 1'b0;
    @(posedge clk); #2;

    issue(1, 1'b0, 32'd0,    32'h0, W1+3, 32'h0ab2112a, "rd_w0");
    issue(1, 1'b1, 32'd16,   32'h0ab21123, W1+3, 32'h0, "wr_a16");
    issue(1, 1'b0, 32'd19,   32'h0, W1+3, 32'h0ab21123, "rd_a19_alias");
    issue(1, 1'b0, 32'd16,   32'h0, W1+3, 32'h0ab21123, "rd_a16");
    issue(1, 1'b1, 32'd1020, 32'hdeadbeef, W1+3, 32'h0, "wr_top");
    issue(1, 1'b0, 32'd1023, 32'h0, W1+3, 32'hdeadbeef, "rd_top_alias");

    // one past the window (would alias word 0 if decode were wrong)
    drive(1, 1'b1, 1'b1, 32'd1024, 32'h55555555, 1'b1);
    repeat (20) @(posedge clk);
    #2; drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(posedge clk); #2;
    issue(1, 1'b0, 32'd0, 32'h0, W1+3, 32'h0ab2112a, "rd_w0_after_oow");

    // write aborted after one wait cycle
    drive(1, 1'b1, 1'b1, 32'd8, 32'hbad0bad0, 1'b1);
    @(posedge clk); #2; den1 = 1'b0;
    @(posedge clk); #2; req1 = 1'b0;
    repeat (2) begin @(posedge clk); #2; end
    issue(1, 1'b0, 32'd8, 32'h0, W1+3, 32'h11112222, "rd_a8_after_abort");

    // reset during the wait phase of a write
    drive(1, 1'b1, 1'b1, 32'd24, 32'hbad1bad1, 1'b1);
    @(posedge clk); #2;
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    clr = 1'b1;
    @(posedge clk); #2; clr = 1'b0;
    @(posedge clk); #2;
    issue(1, 1'b0, 32'd24, 32'h0, W1+3, 32'h24242424, "rd_a24_after_rst");

    // request held well past the response: exactly one strobe
    issue(1, 1'b0, 32'd0,  32'h0, W1+8, 32'h0ab2112a, "rd_hold");
    issue(1, 1'b0, 32'd16, 32'h0, W1+3, 32'h0ab21123, "rd_after_hold");

    // asynchronous reset in the middle of a read response
    drive(1, 1'b1, 1'b0, 32'd0, 32'h0, 1'b0);
    repeat (W1+1) @(posedge clk);
    #1;
    chk("resp_ready_before_clr", {31'b0, rdy1}, 32'd1);
    chk("resp_data_before_clr", bus1, 32'h0ab2112a);
    #1; clr = 1'b1;
    #1;
    chk("ready_after_async_clr", {31'b0, rdy1}, 32'd0);
    chk("bus_after_async_clr", bus1, ALL1);
    req1 = 1'b0;
    @(posedge clk); #2; clr = 1'b0;
    @(posedge clk); #2;
    issue(1, 1'b0, 32'd16, 32'h0, W1+3, 32'h0ab21123, "rd_after_clr");

    // zero wait states
    issue(0, 1'b1, 32'd4, 32'h00005a5a, W0+3, 32'h0, "d0_wr_a4");
    issue(0, 1'b0, 32'd7, 32'h0, W0+3, 32'h00005a5a, "d0_rd_a7_alias");
    issue(0, 1'b1, 32'd8, 32'h3c3c0f0f, W0+3, 32'h0, "d0_wr_a8");
    issue(0, 1'b0, 32'd8, 32'h0, W0+6, 32'h3c3c0f0f, "d0_rd_a8_hold");

    repeat (4) @(posedge clk);
    #2;
    chk("dut1_missing_responses", q1.size(), 32'd0);
    chk("dut0_missing_responses", q0.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
